// File: rtl/vote_pkg.sv
// Shared types and constants for the voting-round tally block.
package vote_pkg;

    typedef enum logic [1:0] {IDLE, COLLECT, DECIDE, DONE} state_t;

    localparam logic [2:0] RES_PASS = 3'b100;
    localparam logic [2:0] RES_TIE  = 3'b010;
    localparam logic [2:0] RES_FAIL = 3'b001;

    // Counter width able to hold 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/vote_round_tally_if.sv
// Vote-input and decision-output bundle between the voter front-end and the tally block.
interface vote_round_tally_if #(
    parameter int N_VOTERS = 4
);
    import vote_pkg::*;

    localparam int CW = cnt_width(N_VOTERS);

    logic                start;
    logic [N_VOTERS-1:0] vote_valid;
    logic [N_VOTERS-1:0] vote_val;
    logic                busy;
    logic [N_VOTERS-1:0] voted;
    logic [CW-1:0]       yes_cnt;
    logic [CW-1:0]       no_cnt;
    logic                done;
    logic [2:0]          result;
    logic                no_quorum;

    modport master (
        output start, vote_valid, vote_val,
        input  busy, voted, yes_cnt, no_cnt, done, result, no_quorum
    );

    modport slave (
        input  start, vote_valid, vote_val,
        output busy, voted, yes_cnt, no_cnt, done, result, no_quorum
    );

endinterface

// File: rtl/vote_popcount.sv
// Combinational population count of an N-bit vector.
module vote_popcount #(
    parameter int N  = 4,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  bits,
    output logic [CW-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/vote_round_tally.sv
// Multi-cycle voting round: collects one vote per voter, closes on full turnout or timeout.
// Optional VOTE_CHAIR_CAST_EN: voter 0 breaks ties with its own vote.
//
// state   | meaning
// IDLE    | waiting for start; previous round's result held
// COLLECT | accepting first vote from each voter, timer running
// DECIDE  | compute result and quorum from final counts
// DONE    | done pulse, result valid
module vote_round_tally
    import vote_pkg::*;
#(
    parameter int N_VOTERS = 4,
    parameter int TIMEOUT  = 16,
    parameter int QUORUM   = 3
) (
    input logic              clk,
    input logic              rst,
    vote_round_tally_if.slave bus
);

    localparam int CW = cnt_width(N_VOTERS);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0]       T_LAST    = TW'(TIMEOUT - 1);
    localparam logic [N_VOTERS-1:0] ALL_VOTED = '1;

    state_t              state_q, state_d;
    logic [N_VOTERS-1:0] voted_q, voted_d;
    logic [CW-1:0]       yes_q, yes_d, no_q, no_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [2:0]          result_q, result_d;
    logic                no_quorum_q, no_quorum_d;
`ifdef VOTE_CHAIR_CAST_EN
    logic                chair_q, chair_d;
`endif

    logic [N_VOTERS-1:0] accept, new_yes, new_no;
    logic [CW-1:0]       yes_inc, no_inc;
    logic [CW:0]         cast_total;

    // A voter is only counted on its first strobe of the round.
    assign accept  = bus.vote_valid & ~voted_q;
    assign new_yes = accept & bus.vote_val;
    assign new_no  = accept & ~bus.vote_val;

    vote_popcount #(.N(N_VOTERS), .CW(CW)) u_pop_yes (.bits(new_yes), .count(yes_inc));
    vote_popcount #(.N(N_VOTERS), .CW(CW)) u_pop_no  (.bits(new_no),  .count(no_inc));

    assign cast_total = {1'b0, yes_q} + {1'b0, no_q};

    always_comb begin
        state_d     = state_q;
        voted_d     = voted_q;
        yes_d       = yes_q;
        no_d        = no_q;
        timer_d     = timer_q;
        result_d    = result_q;
        no_quorum_d = no_quorum_q;
`ifdef VOTE_CHAIR_CAST_EN
        chair_d     = chair_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = COLLECT;
                    voted_d     = '0;
                    yes_d       = '0;
                    no_d        = '0;
                    timer_d     = '0;
                    result_d    = '0;
                    no_quorum_d = 1'b0;
`ifdef VOTE_CHAIR_CAST_EN
                    chair_d     = 1'b0;
`endif
                end
            end
            COLLECT: begin
                voted_d = voted_q | accept;
                yes_d   = yes_q + yes_inc;
                no_d    = no_q + no_inc;
                timer_d = timer_q + TW'(1);
`ifdef VOTE_CHAIR_CAST_EN
                if (accept[0]) chair_d = bus.vote_val[0];
`endif
                if (voted_d == ALL_VOTED || timer_q == T_LAST) state_d = DECIDE;
            end
            DECIDE: begin
                if (yes_q > no_q)      result_d = RES_PASS;
                else if (no_q > yes_q) result_d = RES_FAIL;
                else                   result_d = RES_TIE;
`ifdef VOTE_CHAIR_CAST_EN
                if (yes_q == no_q && voted_q[0]) result_d = chair_q ? RES_PASS : RES_FAIL;
`endif
                no_quorum_d = cast_total < (CW + 1)'(QUORUM);
                state_d     = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            voted_q     <= '0;
            yes_q       <= '0;
            no_q        <= '0;
            timer_q     <= '0;
            result_q    <= '0;
            no_quorum_q <= 1'b0;
`ifdef VOTE_CHAIR_CAST_EN
            chair_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            voted_q     <= voted_d;
            yes_q       <= yes_d;
            no_q        <= no_d;
            timer_q     <= timer_d;
            result_q    <= result_d;
            no_quorum_q <= no_quorum_d;
`ifdef VOTE_CHAIR_CAST_EN
            chair_q     <= chair_d;
`endif
        end
    end

    assign bus.busy      = (state_q == COLLECT) || (state_q == DECIDE);
    assign bus.done      = (state_q == DONE);
    assign bus.voted     = voted_q;
    assign bus.yes_cnt   = yes_q;
    assign bus.no_cnt    = no_q;
    assign bus.result    = result_q;
    assign bus.no_quorum = no_quorum_q;

endmodule

// File: doc/vote_round_tally.md
Name: vote_round_tally

Overview:
- Sequential, parametrised successor to the combinational 4-input voter.
- Opens a voting round on `start`, collects at most one yes/no vote per voter over several cycles, and closes the round when every voter has voted or a timeout expires.
- Publishes the tallies and a one-hot {pass, tie, fail} decision, with a quorum flag.
- Sits between the per-voter input logic and the decision consumer.

Parameters:
- N_VOTERS, 4, number of voters, 2..32.
- TIMEOUT, 16, cycles spent in COLLECT before a forced close, >=2.
- QUORUM, 3, minimum votes cast (yes+no) for a valid decision, 1..N_VOTERS.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  opens a round; sampled only in IDLE.
- vote_valid  in  N_VOTERS  per-voter vote strobe.
- vote_val  in  N_VOTERS  per-voter vote value: 1=yes, 0=no; qualified by vote_valid.
- busy  out  1  high in COLLECT and DECIDE.
- voted  out  N_VOTERS  mask of voters whose vote was accepted this round.
- yes_cnt  out  CW  accepted yes votes; CW=$clog2(N_VOTERS+1).
- no_cnt  out  CW  accepted no votes.
- done  out  1  one-cycle pulse when the result becomes valid.
- result  out  3  one-hot decision: [2]=pass, [1]=tie, [0]=fail; held until the next start.
- no_quorum  out  1  yes_cnt+no_cnt < QUORUM; held with result.

Behaviour:
- Reset (synchronous, any state, including mid-round):
  - state=IDLE.
  - All outputs 0: busy, voted, yes_cnt, no_cnt, done, result=3'b000, no_quorum.
  - Timer=0.
- IDLE:
  - start=1 -> COLLECT next cycle. On that same edge: voted, yes_cnt, no_cnt and timer clear to 0; result and no_quorum clear to 0.
  - Votes presented in IDLE are ignored.
- COLLECT:
  - For each voter i with vote_valid[i]=1 and voted[i]=0, the vote is accepted: voted[i]<=1 and the matching counter increments.
  - Multiple voters in the same cycle are all counted; the increment equals the popcount of newly accepted yes (or no) votes.
  - Repeat votes from a voter already marked in voted are ignored (first vote wins).
  - The timer increments every cycle.
  - Exit to DECIDE when, after this cycle's acceptances, voted is all-ones, OR when timer==TIMEOUT-1. A vote arriving in the timeout cycle is still counted.
  - start is ignored while in COLLECT.
- DECIDE (exactly 1 cycle):
  - yes>no -> pass.
  - no>yes -> fail.
  - Equal, including 0:0 -> tie.
  - no_quorum computed as defined above; result is reported regardless of quorum.
  - Next state DONE.
- DONE (1 cycle):
  - done=1 and result/no_quorum are valid.
  - -> IDLE; result, no_quorum, counts and voted are held.
- Latency: last vote accepted at edge E -> DECIDE during the cycle after E -> done=1 in the following cycle (two cycles after the accepting edge).
- A start asserted in the DONE cycle is ignored; start must be asserted in IDLE.
- Counters cannot overflow: each voter is counted at most once and CW covers N_VOTERS.

Optional Feature:
- Macro: VOTE_CHAIR_CAST_EN.
- Defined: on a tie, voter 0 acts as chair and casts the deciding vote.
  - voted[0]=1 with yes -> pass.
  - voted[0]=1 with no -> fail.
  - Voter 0 abstained -> tie remains.
  - The counts are not altered.
- Undefined: ties are always reported as tie.

Decomposition:
- Package vote_pkg:
  - state typedef enum {IDLE, COLLECT, DECIDE, DONE}.
  - Result one-hot localparams RES_PASS=3'b100, RES_TIE=3'b010, RES_FAIL=3'b001.
  - CW width function.
- One sub-module: vote_popcount, a parametrised N-bit popcount used for the new-yes and new-no increments.

Test Plan (N_VOTERS=4, TIMEOUT=16, QUORUM=3):
- Reset then start; vote_val=4'b0111 with vote_valid=4'b1111 in one cycle -> yes_cnt=3, no_cnt=1, result=100, no_quorum=0, done exactly two cycles after the accepting edge.
- Votes spread over cycles: v0=yes, v1=no, v2=yes, v3=no -> result=010 (tie); with VOTE_CHAIR_CAST_EN -> result=100.
- Only v1=no and v2=no cast, then no further votes -> timeout closes COLLECT after 16 cycles; result=001, no_quorum=1, voted=4'b0110.
- v0 votes yes, then v0 re-votes no, then v1..v3 vote yes -> yes_cnt=4, no_cnt=0, result=100 (duplicate ignored).
- Vote from v3 in the timeout cycle -> counted; votes and start while in IDLE -> no count change.
- rst asserted mid-COLLECT with yes_cnt=2 -> next cycle all outputs 0, state IDLE; a new start gives a clean round.
